// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue controller:
// op codes, FSM states, default latencies.
package mdu_issue_ctrl_pkg;

    localparam int CNT_W_DEF    = 5;
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_NONE  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A zero latency cannot be counted down; run it as one cycle.
    function automatic int lat_clamp(input int lat);
        return (lat < 1) ? 1 : lat;
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// E-stage / D-stage handshake bundle between the pipeline
// and the MDU issue controller.
interface mdu_issue_ctrl_if;

    logic       req;
    logic       e_valid;
    logic [3:0] e_op;
    logic       d_md_use;
    logic       mdu_start;
    logic [3:0] mdu_op;
    logic       hi_we;
    logic       lo_we;
    logic       hilo_commit;
    logic       busy;
    logic       stall_d;
    logic       proto_err;

    modport master (
        output req, e_valid, e_op, d_md_use,
        input  mdu_start, mdu_op, hi_we, lo_we,
        input  hilo_commit, busy, stall_d, proto_err
    );

    modport slave (
        input  req, e_valid, e_op, d_md_use,
        output mdu_start, mdu_op, hi_we, lo_we,
        output hilo_commit, busy, stall_d, proto_err
    );

endinterface

// File: rtl/mdu_lat_counter.sv
// Down-counter timing an MDU operation; flags the last
// busy cycle when the count reaches one.
module mdu_lat_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_one
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_one = (cnt == W'(1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU sequencer: start pulse, HI/LO commit, D-stall.
// Define MDU_STALL_STAT_EN to add stall_cnt/op_cnt counters.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mdu_issue_ctrl_if.slave bus
`ifdef MDU_STALL_STAT_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [31:0]    op_cnt
`endif
);

    localparam logic [CNT_W-1:0] MULT_LD =
        CNT_W'(lat_clamp(MULT_LAT));
    localparam logic [CNT_W-1:0] DIV_LD  =
        CNT_W'(lat_clamp(DIV_LAT));

    state_t state;
    logic   busy_q;
    logic   commit_q;
    logic   perr_q;

    logic   is_arith;
    logic   is_div;
    logic   is_mt;
    logic   idle;
    logic   issue;
    logic   op_bad;
    logic   cnt_one;

    always_comb begin
        is_arith = 1'b0;
        is_div   = 1'b0;
        is_mt    = 1'b0;
        unique case (1'b1)
            (bus.e_op == OP_MULT),
            (bus.e_op == OP_MULTU): is_arith = 1'b1;
            (bus.e_op == OP_DIV),
            (bus.e_op == OP_DIVU): begin
                is_arith = 1'b1;
                is_div   = 1'b1;
            end
            (bus.e_op == OP_MTHI),
            (bus.e_op == OP_MTLO): is_mt = 1'b1;
            default: ;
        endcase
    end

    assign idle   = (state == S_IDLE);
    assign issue  = bus.e_valid & is_arith & ~bus.req & idle;
    assign op_bad = bus.e_valid & (is_arith | is_mt) & ~idle;

    mdu_lat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (issue),
        .load_val (is_div ? DIV_LD : MULT_LD),
        .dec      (state == S_BUSY),
        .is_one   (cnt_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            commit_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            if (op_bad) begin
                perr_q <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (issue) begin
                        state  <= S_BUSY;
                        busy_q <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (cnt_one) begin
                        state    <= S_DONE;
                        commit_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mdu_start   = issue;
    assign bus.mdu_op      = issue ? bus.e_op : OP_NONE;
    assign bus.hi_we       = bus.e_valid & ~bus.req & idle
                           & (bus.e_op == OP_MTHI);
    assign bus.lo_we       = bus.e_valid & ~bus.req & idle
                           & (bus.e_op == OP_MTLO);
    assign bus.hilo_commit = commit_q;
    assign bus.busy        = busy_q;
    assign bus.stall_d     = bus.d_md_use & (busy_q | issue);
    assign bus.proto_err   = perr_q;

`ifdef MDU_STALL_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            op_cnt    <= '0;
        end else begin
            if (bus.stall_d) stall_cnt <= stall_cnt + 32'd1;
            if (issue)       op_cnt    <= op_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: directed plan plus
// random traffic against an occupancy-window reference model.
module tb_mdu_issue_ctrl;

    localparam int L_MULT = 5;
    localparam int L_DIV  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if bus ();

`ifdef MDU_STALL_STAT_EN
    logic [31:0] stall_cnt;
    logic [31:0] op_cnt;
`endif

    mdu_issue_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef MDU_STALL_STAT_EN
        ,
        .stall_cnt (stall_cnt),
        .op_cnt    (op_cnt)
`endif
    );

    typedef struct {
        int          cyc;
        logic        start;
        logic [3:0]  op;
        logic        hi_we;
        logic        lo_we;
        logic        commit;
        logic        busy;
        logic        stall;
        logic        perr;
        logic [31:0] opc;
        logic [31:0] stc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: an op issued in cycle t occupies the MDU
    // for cycles t+1 .. t+L+1 and commits in the last of them.
    int          cyc      = 0;
    int          free_cyc = 0;
    logic        m_perr   = 1'b0;
    logic [31:0] m_opc    = '0;
    logic [31:0] m_stc    = '0;

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act,
                       input logic [31:0] req_v);
        n_chk++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, c, act, req_v);
        end
    endtask

    task automatic step(input logic rst, input logic rq,
                        input logic v, input logic [3:0] op,
                        input logic dmd);
        exp_t e;
        logic occ, arith, mt, iss;
        int   lat;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.req      = rq;
        bus.e_valid  = v;
        bus.e_op     = op;
        bus.d_md_use = dmd;
        occ   = (cyc < free_cyc);
        arith = (op <= 4'd3);
        mt    = (op == 4'd6) || (op == 4'd7);
        iss   = v && arith && !rq && !occ;
        e.cyc    = cyc;
        e.start  = iss;
        e.op     = iss ? op : 4'hF;
        e.hi_we  = v && !rq && !occ && (op == 4'd6);
        e.lo_we  = v && !rq && !occ && (op == 4'd7);
        e.commit = occ && (cyc == free_cyc - 1);
        e.busy   = occ;
        e.stall  = dmd && (occ || iss);
        e.perr   = m_perr;
        e.opc    = m_opc;
        e.stc    = m_stc;
        exp_q.push_back(e);
        if (rst) begin
            free_cyc = cyc + 1;
            m_perr   = 1'b0;
            m_opc    = '0;
            m_stc    = '0;
        end else begin
            lat = (op >= 4'd2) ? L_DIV : L_MULT;
            if (lat < 1) lat = 1;
            if (iss) free_cyc = cyc + lat + 2;
            if (v && (arith || mt) && occ) m_perr = 1'b1;
            if (iss) m_opc = m_opc + 32'd1;
            if (e.stall) m_stc = m_stc + 32'd1;
        end
        cyc++;
    endtask

    task automatic idle_n(input int n, input logic dmd);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, dmd);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mdu_start", e.cyc, 32'(bus.mdu_start), 32'(e.start));
                chk("mdu_op", e.cyc, 32'(bus.mdu_op), 32'(e.op));
                chk("hi_we", e.cyc, 32'(bus.hi_we), 32'(e.hi_we));
                chk("lo_we", e.cyc, 32'(bus.lo_we), 32'(e.lo_we));
                chk("hilo_commit", e.cyc, 32'(bus.hilo_commit),
                    32'(e.commit));
                chk("busy", e.cyc, 32'(bus.busy), 32'(e.busy));
                chk("stall_d", e.cyc, 32'(bus.stall_d), 32'(e.stall));
                chk("proto_err", e.cyc, 32'(bus.proto_err),
                    32'(e.perr));
`ifdef MDU_STALL_STAT_EN
                chk("op_cnt", e.cyc, op_cnt, e.opc);
                chk("stall_cnt", e.cyc, stall_cnt, e.stc);
`endif
            end
        end
    end

    initial begin : stim
        bus.req      = 1'b0;
        bus.e_valid  = 1'b0;
        bus.e_op     = 4'hF;
        bus.d_md_use = 1'b0;
        repeat (3) @(posedge clk);

        // reset state, then mult at cycle 0
        step(1, 0, 0, 4'd0, 0);
        step(0, 0, 1, 4'd0, 0);
        idle_n(8, 0);
        // div with D-stage MD use held
        step(0, 0, 1, 4'd2, 1);
        idle_n(14, 1);
        // mult and mthi blocked by req
        step(0, 1, 1, 4'd0, 0);
        step(0, 1, 1, 4'd6, 0);
        step(0, 0, 1, 4'd6, 0);
        step(0, 0, 1, 4'd7, 0);
        idle_n(2, 0);
        // req mid-flight on multu
        step(0, 0, 1, 4'd1, 0);
        idle_n(2, 0);
        step(0, 1, 0, 4'd0, 1);
        idle_n(6, 0);
        // reset during div, then mult accepted
        step(0, 0, 1, 4'd3, 0);
        idle_n(3, 0);
        step(1, 0, 0, 4'd0, 0);
        step(0, 0, 1, 4'd0, 0);
        // mtlo while busy: protocol error, sticky
        step(0, 0, 1, 4'd7, 0);
        idle_n(8, 0);
        // two divs and a mult from a clean reset
        step(1, 0, 0, 4'd0, 0);
        step(0, 0, 1, 4'd2, 0);
        idle_n(12, 0);
        step(0, 0, 1, 4'd3, 1);
        idle_n(12, 0);
        step(0, 0, 1, 4'd0, 0);
        idle_n(8, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 9));
            if (op > 4'd7) op = 4'($urandom_range(8, 15));
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0),
                 op,
                 ($urandom_range(0, 1) == 1));
        end
        idle_n(3, 0);

        repeat (2) @(negedge clk);
        chk("queue_drained", cyc, 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
